// File: rtl/dmem_wait_responder.sv
// Fixed-latency data memory for the MEM stage: captures one request, waits
// LATENCY cycles, commits the access and pulses ready_o for one cycle.
module dmem_wait_responder #(
   parameter int ADDR_W  = 7,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ready_o,
   output logic        stall_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         data_q;
   logic [31:0]         mem_q [DEPTH];
   logic                req;
   logic                commit;
   logic                unused_addr;

   assign req         = MemRead_i | MemWrite_i;
   assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

   // The _d capture values double as the commit target, so a zero-latency
   // access can commit on the same edge that captures it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               wr_d    = MemWrite_i;
               idx_d   = addr_i[ADDR_W+1:2];
               wdata_d = data_i;
               if (LATENCY > 0) begin
                  state_d = BUSY;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = RESP;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      commit = (state_d == RESP);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         if (commit && !wr_d) data_q <= mem_q[idx_d];
      end
   end

   // Memory words are plain flops: every word must clear on reset.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i)
            mem_q[gi] <= '0;
         else if (commit && wr_d && (idx_d == ADDR_W'(gi)))
            mem_q[gi] <= wdata_d;
      end
   end

   assign data_o  = data_q;
   assign ready_o = (state_q == RESP);
   assign stall_o = req & ~ready_o;

endmodule
